// File: rtl/lsu_pkg.sv
// lsu_pkg: state encoding, RV32I load/store funct3 codes and memory sign_mask constants
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} lsu_state_e;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [3:0] SM_BYTE   = 4'b0001;
  localparam logic [3:0] SM_HALF   = 4'b0011;
  localparam logic [3:0] SM_WORD   = 4'b0111;
  localparam logic [3:0] SM_SIGNED = 4'b1000;
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    return sz == F3_B[1:0] ? SM_BYTE : sz == F3_H[1:0] ? SM_HALF : SM_WORD;
  endfunction
endpackage

// File: rtl/lsu_if.sv
// lsu_if: pipeline request/response and data-memory signals of the load/store unit
//   slave  : LSU view (takes requests, returns responses, drives memory strobes/buses)
//   master : pipeline + memory view
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data;
  logic        mem_clk_stall;
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_read_data, mem_clk_stall,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_write_data, mem_memwrite,
           mem_memread, mem_sign_mask
  );
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_read_data, mem_clk_stall,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_write_data, mem_memwrite,
           mem_memread, mem_sign_mask
  );
endinterface

// File: rtl/lsu_decode.sv
// lsu_decode: maps (we, funct3, addr[1:0]) to memory sign_mask, legality and misalignment
//   we, funct3, addr_lo : request fields
//   sign_mask           : {signed, size} encoding, 0 for illegal funct3
//   legal, misaligned   : request classification
module lsu_decode
  import lsu_pkg::*;
(
  input  logic       we,
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  output logic [3:0] sign_mask,
  output logic       legal,
  output logic       misaligned
);
  always_comb begin
    legal      = funct3 == F3_B || funct3 == F3_H || funct3 == F3_W || (!we && (funct3 == F3_BU || funct3 == F3_HU));
    misaligned = (funct3[1:0] == F3_H[1:0] && addr_lo[0]) || (funct3[1:0] == F3_W[1:0] && addr_lo != 2'b00);
    sign_mask  = legal ? (size_mask(funct3[1:0]) | ((we || funct3[2]) ? 4'b0000 : SM_SIGNED)) : 4'b0000;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding RV32I load/store sequencer (IDLE/ISSUE/WAIT/RESP)
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : lsu_if.slave -- request/response handshake and data-memory port
//   txn_count  : internal count of completed responses, visible by hierarchy only
module load_store_unit
  import lsu_pkg::*;
(
  input logic   clk,
  input logic   rst_n,
  lsu_if.slave  bus
);
  lsu_state_e  state;
  logic [31:0] txn_count;
  logic        r_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [3:0]  mem_sign_mask;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [3:0]  dec_mask;
  logic        dec_legal;
  logic        dec_mis;
  lsu_decode u_decode (
    .we         (bus.req_we),
    .funct3     (bus.req_funct3),
    .addr_lo    (bus.req_addr[1:0]),
    .sign_mask  (dec_mask),
    .legal      (dec_legal),
    .misaligned (dec_mis)
  );
  assign bus.req_ready      = state == IDLE;
  assign bus.resp_valid     = resp_valid;
  assign bus.resp_err       = resp_err;
  assign bus.resp_rdata     = resp_rdata;
  assign bus.mem_addr       = mem_addr;
  assign bus.mem_write_data = mem_write_data;
  assign bus.mem_memwrite   = mem_memwrite;
  assign bus.mem_memread    = mem_memread;
  assign bus.mem_sign_mask  = mem_sign_mask;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      txn_count      <= '0;
      r_we           <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_memwrite   <= 1'b0;
      mem_memread    <= 1'b0;
      mem_sign_mask  <= '0;
      resp_valid     <= 1'b0;
      resp_err       <= 1'b0;
      resp_rdata     <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          r_we           <= bus.req_we;
          mem_addr       <= bus.req_addr;
          mem_write_data <= bus.req_wdata;
          mem_sign_mask  <= dec_mask;
          if (dec_legal && !dec_mis) begin
            state        <= ISSUE;
            mem_memread  <= !bus.req_we;
            mem_memwrite <= bus.req_we;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end
        end
        // strobe and buses stay put while the memory reports a stall
        ISSUE: if (!bus.mem_clk_stall) begin
          mem_memread  <= 1'b0;
          mem_memwrite <= 1'b0;
          if (r_we) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= bus.mem_read_data;
        end
        RESP: if (bus.resp_ready) begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          txn_count  <= txn_count + 32'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit
module tb_load_store_unit;
  import lsu_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  lsu_if bus();
  load_store_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    tick;
    bus.req_valid  = 1'b0;
  endtask
  initial begin
    bus.req_valid     = 1'b0;
    bus.req_we        = 1'b0;
    bus.req_funct3    = 3'b000;
    bus.req_addr      = '0;
    bus.req_wdata     = '0;
    bus.resp_ready    = 1'b1;
    bus.mem_read_data = '0;
    bus.mem_clk_stall = 1'b0;
    tick;
    tick;
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_write_data, 32'd0);
    chk("rst_strobes", {30'd0, bus.mem_memread, bus.mem_memwrite}, 32'd0);
    chk("rst_sign_mask", 32'(bus.mem_sign_mask), 32'd0);
    chk("rst_txn", dut.txn_count, 32'd0);
    rst_n = 1'b1;
    tick;
    // LB at 0x1003, memory returns already sign-extended byte
    bus.mem_read_data = 32'hFFFFFF80;
    send(1'b0, 3'b000, 32'h0000_1003, 32'h0);
    chk("lb_c1_read", 32'(bus.mem_memread), 32'd1);
    chk("lb_c1_write", 32'(bus.mem_memwrite), 32'd0);
    chk("lb_c1_mask", 32'(bus.mem_sign_mask), 32'b1001);
    chk("lb_c1_addr", bus.mem_addr, 32'h0000_1003);
    chk("lb_c1_valid", 32'(bus.resp_valid), 32'd0);
    chk("lb_c1_ready", 32'(bus.req_ready), 32'd0);
    tick;
    chk("lb_c2_strobes", {30'd0, bus.mem_memread, bus.mem_memwrite}, 32'd0);
    chk("lb_c2_valid", 32'(bus.resp_valid), 32'd0);
    tick;
    chk("lb_c3_valid", 32'(bus.resp_valid), 32'd1);
    chk("lb_c3_rdata", bus.resp_rdata, 32'hFFFFFF80);
    chk("lb_c3_err", 32'(bus.resp_err), 32'd0);
    tick;
    chk("lb_done_ready", 32'(bus.req_ready), 32'd1);
    chk("lb_done_valid", 32'(bus.resp_valid), 32'd0);
    chk("lb_done_txn", dut.txn_count, 32'd1);
    // SH at 0x1002
    send(1'b1, 3'b001, 32'h0000_1002, 32'h1234ABCD);
    chk("sh_c1_write", 32'(bus.mem_memwrite), 32'd1);
    chk("sh_c1_read", 32'(bus.mem_memread), 32'd0);
    chk("sh_c1_mask", 32'(bus.mem_sign_mask), 32'b0011);
    chk("sh_c1_wdata", bus.mem_write_data, 32'h1234ABCD);
    chk("sh_c1_addr", bus.mem_addr, 32'h0000_1002);
    chk("sh_c1_valid", 32'(bus.resp_valid), 32'd0);
    tick;
    chk("sh_c2_write", 32'(bus.mem_memwrite), 32'd0);
    chk("sh_c2_valid", 32'(bus.resp_valid), 32'd1);
    chk("sh_c2_err", 32'(bus.resp_err), 32'd0);
    chk("sh_c2_rdata", bus.resp_rdata, 32'd0);
    tick;
    chk("sh_done_txn", dut.txn_count, 32'd2);
    // LW at 0x1001 is misaligned: immediate error, no strobe
    send(1'b0, 3'b010, 32'h0000_1001, 32'h0);
    chk("lw_mis_valid", 32'(bus.resp_valid), 32'd1);
    chk("lw_mis_err", 32'(bus.resp_err), 32'd1);
    chk("lw_mis_rdata", bus.resp_rdata, 32'd0);
    chk("lw_mis_strobes", {30'd0, bus.mem_memread, bus.mem_memwrite}, 32'd0);
    tick;
    chk("lw_mis_idle_strobes", {30'd0, bus.mem_memread, bus.mem_memwrite}, 32'd0);
    chk("lw_mis_txn", dut.txn_count, 32'd3);
    // store with funct3=100 is illegal
    send(1'b1, 3'b100, 32'h0000_1000, 32'h5555_5555);
    chk("sbu_ill_err", 32'(bus.resp_err), 32'd1);
    chk("sbu_ill_strobes", {30'd0, bus.mem_memread, bus.mem_memwrite}, 32'd0);
    tick;
    chk("sbu_ill_txn", dut.txn_count, 32'd4);
    // SW with memory stalled for 3 cycles
    send(1'b1, 3'b010, 32'h0000_2000, 32'hDEADBEEF);
    bus.mem_clk_stall = 1'b1;
    chk("sw_c1_write", 32'(bus.mem_memwrite), 32'd1);
    chk("sw_c1_mask", 32'(bus.mem_sign_mask), 32'b0111);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("sw_stall_write", 32'(bus.mem_memwrite), 32'd1);
      chk("sw_stall_addr", bus.mem_addr, 32'h0000_2000);
      chk("sw_stall_wdata", bus.mem_write_data, 32'hDEADBEEF);
      chk("sw_stall_valid", 32'(bus.resp_valid), 32'd0);
    end
    bus.mem_clk_stall = 1'b0;
    tick;
    chk("sw_rel_write", 32'(bus.mem_memwrite), 32'd0);
    chk("sw_rel_valid", 32'(bus.resp_valid), 32'd1);
    tick;
    chk("sw_done_txn", dut.txn_count, 32'd5);
    // LHU with the response held off for 5 cycles
    bus.mem_read_data = 32'h0000BEEF;
    bus.resp_ready = 1'b0;
    send(1'b0, 3'b101, 32'h0000_3002, 32'h0);
    chk("lhu_c1_mask", 32'(bus.mem_sign_mask), 32'b0011);
    chk("lhu_c1_read", 32'(bus.mem_memread), 32'd1);
    tick;
    tick;
    chk("lhu_c3_valid", 32'(bus.resp_valid), 32'd1);
    chk("lhu_c3_rdata", bus.resp_rdata, 32'h0000BEEF);
    bus.mem_read_data = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("lhu_hold_valid", 32'(bus.resp_valid), 32'd1);
      chk("lhu_hold_rdata", bus.resp_rdata, 32'h0000BEEF);
      chk("lhu_hold_ready", 32'(bus.req_ready), 32'd0);
      chk("lhu_hold_txn", dut.txn_count, 32'd5);
    end
    bus.resp_ready = 1'b1;
    tick;
    chk("lhu_done_ready", 32'(bus.req_ready), 32'd1);
    chk("lhu_done_valid", 32'(bus.resp_valid), 32'd0);
    chk("lhu_done_txn", dut.txn_count, 32'd6);
    // reset pulsed while waiting for load data
    bus.mem_read_data = 32'hCAFEF00D;
    send(1'b0, 3'b010, 32'h0000_4000, 32'h0);
    tick;
    chk("rstw_in_wait", 32'(dut.state), 32'(WAIT));
    rst_n = 1'b0;
    #1;
    chk("rstw_strobes", {30'd0, bus.mem_memread, bus.mem_memwrite}, 32'd0);
    chk("rstw_valid", 32'(bus.resp_valid), 32'd0);
    chk("rstw_state", 32'(dut.state), 32'(IDLE));
    chk("rstw_txn", dut.txn_count, 32'd0);
    #2;
    rst_n = 1'b1;
    tick;
    chk("rstw_idle_valid", 32'(bus.resp_valid), 32'd0);
    bus.mem_read_data = 32'h0000_00AB;
    send(1'b0, 3'b100, 32'h0000_4001, 32'h0);
    chk("lbu_c1_mask", 32'(bus.mem_sign_mask), 32'b0001);
    chk("lbu_c1_addr", bus.mem_addr, 32'h0000_4001);
    tick;
    tick;
    chk("lbu_c3_valid", 32'(bus.resp_valid), 32'd1);
    chk("lbu_c3_rdata", bus.resp_rdata, 32'h0000_00AB);
    chk("lbu_c3_err", 32'(bus.resp_err), 32'd0);
    tick;
    chk("lbu_done_txn", dut.txn_count, 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
